// File: rtl/cntr_pkg.sv
// Shared encodings for the up/down counter stream decoder: FSM states and step codes.
package cntr_pkg;

   typedef enum logic [1:0] {
      StEmpty,
      StAcq,
      StLock
   } state_e;

   // StepHold doubles as "no class" in the class register: a real class is never a hold.
   typedef enum logic [2:0] {
      StepHold    = 3'd0,
      StepUp1     = 3'd1,
      StepUp2     = 3'd2,
      StepDn1     = 3'd3,
      StepDn2     = 3'd4,
      StepIllegal = 3'd5
   } step_e;

   function automatic logic step_is_up(step_e s);
      return (s == StepUp1) || (s == StepUp2);
   endfunction

   function automatic logic step_is_two(step_e s);
      return (s == StepUp2) || (s == StepDn2);
   endfunction

endpackage

// File: rtl/cntr_step_classify.sv
// Combinational classifier: previous and current 3-bit samples -> step code and wrap flag.
module cntr_step_classify
   import cntr_pkg::*;
(
   input  logic [2:0] prev_i,
   input  logic [2:0] cnt_i,
   output step_e      step_o,
   output logic       wrap_o
);

   logic [2:0] diff;

   always_comb begin
      diff   = cnt_i - prev_i;
      step_o = StepIllegal;
      wrap_o = 1'b0;
      case (diff)
         3'd0: step_o = StepHold;
         3'd1: step_o = StepUp1;
         3'd2: step_o = StepUp2;
         3'd7: step_o = StepDn1;
         3'd6: step_o = StepDn2;
         default: step_o = StepIllegal;
      endcase
      if (step_o == StepUp1 || step_o == StepUp2) begin
         wrap_o = (cnt_i < prev_i);
      end else if (step_o == StepDn1 || step_o == StepDn2) begin
         wrap_o = (cnt_i > prev_i);
      end
   end

endmodule

// File: rtl/cntr_seq_decoder.sv
// Receive-side decoder for the 3-bit up/down counter stream: classifies steps, locks, flags errors.
module cntr_seq_decoder
   import cntr_pkg::*;
#(
   parameter int unsigned LOCK_N = 2,
   parameter int unsigned ERR_W  = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             valid_i,
   input  logic [2:0]       cnt_i,
   output logic             dir_up_o,
   output logic             step2_o,
   output logic             held_o,
   output logic             lock_o,
   output logic             wrap_o,
   output logic             err_o,
   output logic [ERR_W-1:0] err_cnt_o
);

   localparam logic [2:0] LockN = 3'(LOCK_N);

   state_e           state_q, state_d;
   step_e            class_q, class_d;
   logic [2:0]       prev_q, prev_d;
   logic [2:0]       run_q, run_d;
   logic             dir_up_q, dir_up_d;
   logic             step2_q, step2_d;
   logic             held_q, held_d;
   logic             lock_q, lock_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   step_e step;
   logic  step_wrap;

   cntr_step_classify u_classify (
      .prev_i (prev_q),
      .cnt_i  (cnt_i),
      .step_o (step),
      .wrap_o (step_wrap)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= StEmpty;
         class_q   <= StepHold;
         prev_q    <= 3'd0;
         run_q     <= 3'd0;
         dir_up_q  <= 1'b0;
         step2_q   <= 1'b0;
         held_q    <= 1'b0;
         lock_q    <= 1'b0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         prev_q    <= prev_d;
         run_q     <= run_d;
         dir_up_q  <= dir_up_d;
         step2_q   <= step2_d;
         held_q    <= held_d;
         lock_q    <= lock_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      prev_d    = prev_q;
      run_d     = run_q;
      dir_up_d  = dir_up_q;
      step2_d   = step2_q;
      held_d    = held_q;
      lock_d    = lock_q;
      wrap_d    = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;

      if (valid_i) begin
         prev_d = cnt_i;
         unique case (state_q)
            StEmpty: begin
               state_d = StAcq;
               class_d = StepHold;
               run_d   = 3'd0;
            end
            StAcq, StLock: begin
               if (step == StepHold) begin
                  held_d = 1'b1;
               end else if (step == StepIllegal) begin
                  held_d  = 1'b0;
                  err_d   = 1'b1;
                  class_d = StepHold;
                  run_d   = 3'd0;
                  lock_d  = 1'b0;
                  state_d = StAcq;
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + 1'b1;
                  end
               end else begin
                  held_d   = 1'b0;
                  wrap_d   = step_wrap;
                  dir_up_d = step_is_up(step);
                  step2_d  = step_is_two(step);
                  if (step == class_q) begin
                     // Once locked the run count is frozen; only acquisition counts up.
                     if (state_q == StAcq) begin
                        run_d = run_q + 3'd1;
                        if (run_d >= LockN) begin
                           state_d = StLock;
                           lock_d  = 1'b1;
                        end
                     end
                  end else begin
                     class_d = step;
                     run_d   = 3'd1;
                     if (LockN == 3'd1) begin
                        state_d = StLock;
                        lock_d  = 1'b1;
                     end else begin
                        state_d = StAcq;
                        lock_d  = 1'b0;
                     end
                  end
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   assign dir_up_o  = dir_up_q;
   assign step2_o   = step2_q;
   assign held_o    = held_q;
   assign lock_o    = lock_q;
   assign wrap_o    = wrap_q;
   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_cntr_seq_decoder.sv
// Scoreboard bench for cntr_seq_decoder: driver queues expected outputs, monitor checks them.
module tb_cntr_seq_decoder;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       valid_i = 1'b0;
   logic [2:0] cnt_i = 3'd0;
   logic       dir_up_o, step2_o, held_o, lock_o, wrap_o, err_o;
   logic [3:0] err_cnt_o;

   typedef struct {
      logic       dir;
      logic       st2;
      logic       held;
      logic       lock;
      logic       wrap;
      logic       err;
      logic [3:0] ecnt;
      int         tag;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   exp_t last;
   int   edge_cnt = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   cntr_seq_decoder #(.LOCK_N(2), .ERR_W(4)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .valid_i   (valid_i),
      .cnt_i     (cnt_i),
      .dir_up_o  (dir_up_o),
      .step2_o   (step2_o),
      .held_o    (held_o),
      .lock_o    (lock_o),
      .wrap_o    (wrap_o),
      .err_o     (err_o),
      .err_cnt_o (err_cnt_o)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   function automatic logic [9:0] pack_dut();
      return {dir_up_o, step2_o, held_o, lock_o, wrap_o, err_o, err_cnt_o};
   endfunction

   function automatic logic [9:0] pack_exp(exp_t e);
      return {e.dir, e.st2, e.held, e.lock, e.wrap, e.err, e.ecnt};
   endfunction

   task automatic check(string name, logic [9:0] act, logic [9:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got dir/st2/held/lock/wrap/err/cnt=%b want %b", name, act, req);
   endtask

   // Monitor: each entry applies after the posedge it was tagged with.
   always @(negedge CLK) begin
      while (exp_q.size() > 0 && exp_q[0].tag <= edge_cnt) begin
         exp_t e;
         e = exp_q.pop_front();
         check(e.name, pack_dut(), pack_exp(e));
      end
   end

   task automatic push(string name, logic d, logic s2, logic h, logic l, logic w, logic er,
                       logic [3:0] ec);
      exp_t e;
      e.dir = d; e.st2 = s2; e.held = h; e.lock = l; e.wrap = w; e.err = er; e.ecnt = ec;
      e.tag = edge_cnt + 1;
      e.name = name;
      exp_q.push_back(e);
      last = e;
   endtask

   task automatic sample(string name, logic [2:0] c, logic d, logic s2, logic h, logic l,
                         logic w, logic er, logic [3:0] ec);
      @(negedge CLK);
      #1;
      valid_i = 1'b1;
      cnt_i   = c;
      push(name, d, s2, h, l, w, er, ec);
   endtask

   task automatic idle(string name, int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         #1;
         valid_i = 1'b0;
         cnt_i   = 3'(i * 3);
         push(name, last.dir, last.st2, last.held, last.lock, 1'b0, 1'b0, last.ecnt);
      end
   endtask

   task automatic drain();
      int budget = 50;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge CLK);
         budget--;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #12;
      check("reset", pack_dut(), 10'd0);
      RST = 1'b1;

      sample("first", 3'd0, 0, 0, 0, 0, 0, 0, 4'd0);
      sample("up1_a", 3'd1, 1, 0, 0, 0, 0, 0, 4'd0);
      sample("up1_lock", 3'd2, 1, 0, 0, 1, 0, 0, 4'd0);
      sample("up1_c", 3'd3, 1, 0, 0, 1, 0, 0, 4'd0);
      sample("up1_d", 3'd4, 1, 0, 0, 1, 0, 0, 4'd0);
      sample("up2_chg", 3'd6, 1, 1, 0, 0, 0, 0, 4'd0);
      sample("up2_wrap", 3'd0, 1, 1, 0, 1, 1, 0, 4'd0);
      sample("up2_c", 3'd2, 1, 1, 0, 1, 0, 0, 4'd0);
      sample("up2_d", 3'd4, 1, 1, 0, 1, 0, 0, 4'd0);
      sample("up1_chg", 3'd5, 1, 0, 0, 0, 0, 0, 4'd0);
      sample("dn1_a", 3'd4, 0, 0, 0, 0, 0, 0, 4'd0);
      sample("dn1_lock", 3'd3, 0, 0, 0, 1, 0, 0, 4'd0);
      idle("gap_lock", 10);
      sample("hold_a", 3'd3, 0, 0, 1, 1, 0, 0, 4'd0);
      sample("hold_b", 3'd3, 0, 0, 1, 1, 0, 0, 4'd0);
      sample("dn1_after", 3'd2, 0, 0, 0, 1, 0, 0, 4'd0);
      sample("dn2_chg", 3'd0, 0, 1, 0, 0, 0, 0, 4'd0);
      sample("illegal", 3'd4, 0, 1, 0, 0, 0, 1, 4'd1);
      idle("gap_err", 3);
      for (int i = 0; i < 20; i++) begin
         sample("illegal_rep", (i % 2 == 0) ? 3'd0 : 3'd4, 0, 1, 0, 0, 0, 1,
                (i + 2 > 15) ? 4'd15 : 4'(i + 2));
      end
      sample("up1_reacq", 3'd5, 1, 0, 0, 0, 0, 0, 4'd15);
      sample("dn2_a", 3'd3, 0, 1, 0, 0, 0, 0, 4'd15);
      sample("dn2_lock", 3'd1, 0, 1, 0, 1, 0, 0, 4'd15);
      sample("dn2_wrap", 3'd7, 0, 1, 0, 1, 1, 0, 4'd15);
      idle("gap_wrap", 2);
      drain();

      @(negedge CLK);
      #2;
      RST = 1'b0;
      #1;
      check("async_reset", pack_dut(), 10'd0);
      @(negedge CLK);
      RST = 1'b1;
      last.dir = 0; last.st2 = 0; last.held = 0; last.lock = 0; last.ecnt = 4'd0;
      sample("post_rst_first", 3'd6, 0, 0, 0, 0, 0, 0, 4'd0);
      sample("post_rst_wrap", 3'd0, 1, 1, 0, 0, 1, 0, 4'd0);
      idle("gap_end", 3);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded, want finish");
      $fatal(1, "timeout");
   end

endmodule
